asym_width_fifo: RTL and testbench
==================================

Name: asym_width_fifo

Overview:
Single-clock FIFO with independent write and read data widths, such as 8-bit in and 32-bit out, or 32-bit in and 8-bit out. It packs or unpacks narrow words into wide words, lowest-addressed narrow word in the least-significant lane. Storage is a dual-view RAM addressed in narrow-word units. It sits between byte-wide readout/serial front ends and 32-bit bus or DMA logic, and also serves the reverse direction toward serialisers.

Parameters:
WIDTH_IN, 8, write data width in bits.
WIDTH_OUT, 32, read data width in bits.
DEPTH, 64, capacity in narrow words (narrow = min(WIDTH_IN, WIDTH_OUT)); power of two, >= 2*wide/narrow.
- Constraint: max/min width ratio (RATIO) is a power of two, 1..16.
- Constraint: RATIO=1 degenerates to a plain FIFO.

Ports:
CLK  input  1  sole clock, all logic on rising edge
RST_N  input  1  asynchronous active-low reset
FLUSH  input  1  synchronous clear of contents and flags
WRITE  input  1  write request
DATA_IN  input  WIDTH_IN  write data
FULL  output  1  write not accepted this cycle
READ  input  1  pop request (first-word-fall-through)
DATA_OUT  output  WIDTH_OUT  head word, valid while EMPTY=0
EMPTY  output  1  no complete output word presented
SIZE  output  clog2(DEPTH)+1  narrow words held, including the output register
OVF  output  1  sticky: write attempted while FULL
UNF  output  1  sticky: read attempted while EMPTY

Behaviour:
Reset (RST_N=0, asynchronous):
- Pointers, SIZE=0, EMPTY=1, FULL=0, OVF=0, UNF=0, DATA_OUT=0.
- RAM contents are not cleared.

Units and flags:
- WU = WIDTH_IN/narrow; RU = WIDTH_OUT/narrow.
- FULL = (DEPTH - SIZE) < WU, derived from registered state.

Write:
- Accepted at a rising edge when WRITE=1 and FULL=0.
- Stores DATA_IN as WU narrow words, bits [k*narrow +: narrow] at write pointer + k.
- Write pointer advances by WU, modulo DEPTH; wrap is seamless.

Read (first-word-fall-through):
- An output register holds the head wide word. Its lane j = narrow word at read pointer + j.
- EMPTY=0 only while the output register is loaded.
- The output register loads when it is empty or being popped, and at least RU narrow words sit in RAM beyond it.
- A pop is accepted at an edge with READ=1 and EMPTY=0.
- Back-to-back pops sustain one word per cycle while data is available.

Latency:
- A write completing a wide word at edge N gives EMPTY=0 with valid DATA_OUT after edge N+1.
- A pop at edge N frees space, and FULL updates after edge N.
- A pop-and-write at the same edge never blocks the write when FULL=0 before the edge.

Partial words:
- Fewer than RU narrow words pending keeps EMPTY=1.
- SIZE still reports the pending count.

Simultaneous events:
- WRITE and READ in the same cycle are both accepted if individually legal.
- SIZE changes by +WU-RU.

Ignored requests:
- WRITE while FULL: ignored, no state change, OVF<=1.
- READ while EMPTY: ignored, UNF<=1.
- OVF and UNF clear only via FLUSH or reset.

FLUSH:
- Synchronous and dominant over WRITE/READ in the same cycle.
- Next edge: pointers, SIZE, output register, OVF and UNF cleared; EMPTY=1, FULL=0.
- Reset or FLUSH mid-packing discards the partial word. No stale lanes ever appear on DATA_OUT afterwards.

Test Plan:
1. 8->32, DEPTH=64: write 0x11,0x22,0x33,0x44 on consecutive cycles.
   -> EMPTY=1 with SIZE=1,2,3, then EMPTY=0 one edge after the 4th write, DATA_OUT=0x44332211. READ pulse -> EMPTY=1, SIZE=0.
2. 32->8, DEPTH=16: write 0xA1B2C3D4, hold READ high.
   -> DATA_OUT 0xD4,0xC3,0xB2,0xA1 on four consecutive cycles, then EMPTY=1.
3. 8->32, DEPTH=16: 16 writes 0x00..0x0F.
   -> FULL=1 after the 16th, SIZE=16. A 17th write (0xFF) is ignored and OVF=1. Then 4 reads return 0x03020100..0x0F0E0D0C.
4. Wrap and simultaneous traffic: 8->32, DEPTH=16, continuous write plus read for 100 words of incrementing bytes.
   -> Output is a gap-free incrementing sequence, SIZE never exceeds 16, OVF=UNF=0.
5. FLUSH and reset: write 3 bytes, assert FLUSH together with WRITE.
   -> Next cycle SIZE=0, EMPTY=1; the written byte is discarded.
   -> Repeat with RST_N pulsed low mid-cycle: outputs clear immediately without a clock edge.
6. READ while EMPTY at reset state.
   -> UNF=1, SIZE stays 0. FLUSH -> UNF=0.

Source files
------------

// File: rtl/asym_width_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : asym_width_fifo
//  Brief    : Single-clock FWFT FIFO with independent write/read widths,
//             packing/unpacking through a RAM addressed in narrow words.
//  Revision : 1.0
// ============================================================================
module asym_width_fifo #(
    parameter int WIDTH_IN  = 8,
    parameter int WIDTH_OUT = 32,
    parameter int DEPTH     = 64
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     FLUSH,
    input  logic                     WRITE,
    input  logic [WIDTH_IN-1:0]      DATA_IN,
    output logic                     FULL,
    input  logic                     READ,
    output logic [WIDTH_OUT-1:0]     DATA_OUT,
    output logic                     EMPTY,
    output logic [$clog2(DEPTH):0]   SIZE,
    output logic                     OVF,
    output logic                     UNF
);

    localparam int c_NARROW = (WIDTH_IN < WIDTH_OUT) ? WIDTH_IN : WIDTH_OUT;
    localparam int c_WU     = WIDTH_IN / c_NARROW;
    localparam int c_RU     = WIDTH_OUT / c_NARROW;
    localparam int c_AW     = $clog2(DEPTH);
    localparam int c_SW     = c_AW + 1;

    localparam logic [c_SW-1:0] c_WU_S    = c_SW'(c_WU);
    localparam logic [c_SW-1:0] c_RU_S    = c_SW'(c_RU);
    localparam logic [c_SW-1:0] c_DEPTH_S = c_SW'(DEPTH);
    localparam logic [c_AW-1:0] c_WU_A    = c_AW'(c_WU);
    localparam logic [c_AW-1:0] c_RU_A    = c_AW'(c_RU);

    logic [c_NARROW-1:0]  r_mem [DEPTH];
    logic [c_AW-1:0]      r_wptr;
    logic [c_AW-1:0]      r_rptr;
    logic [c_SW-1:0]      r_size;
    logic [c_SW-1:0]      r_ram_cnt;
    logic                 r_valid;
    logic [WIDTH_OUT-1:0] r_dout;
    logic                 r_ovf;
    logic                 r_unf;

    logic                 w_full;
    logic                 w_wr;
    logic                 w_pop;
    logic                 w_load;
    logic [WIDTH_OUT-1:0] w_head;

    // r_size counts the output register's lanes too, so their RAM slots
    // are never reused by a write before the word is popped.
    assign w_full = (c_DEPTH_S - r_size) < c_WU_S;
    assign w_wr   = WRITE && !w_full && !FLUSH;
    assign w_pop  = READ && r_valid && !FLUSH;
    assign w_load = (!r_valid || w_pop) && (r_ram_cnt >= c_RU_S) && !FLUSH;

    generate
        for (genvar j = 0; j < c_RU; j++) begin : g_lane
            assign w_head[j*c_NARROW +: c_NARROW] = r_mem[r_rptr + c_AW'(j)];
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (w_wr) begin
            for (int k = 0; k < c_WU; k++) begin
                r_mem[r_wptr + c_AW'(k)] <= DATA_IN[k*c_NARROW +: c_NARROW];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_size    <= '0;
            r_ram_cnt <= '0;
            r_valid   <= 1'b0;
            r_dout    <= '0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
        end else if (FLUSH) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_size    <= '0;
            r_ram_cnt <= '0;
            r_valid   <= 1'b0;
            r_dout    <= '0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + c_WU_A;
            end
            if (w_load) begin
                r_rptr <= r_rptr + c_RU_A;
            end
            r_size    <= r_size + (w_wr ? c_WU_S : '0) - (w_pop ? c_RU_S : '0);
            r_ram_cnt <= r_ram_cnt + (w_wr ? c_WU_S : '0) - (w_load ? c_RU_S : '0);
            if (w_load) begin
                r_valid <= 1'b1;
                r_dout  <= w_head;
            end else if (w_pop) begin
                r_valid <= 1'b0;
            end
            if (WRITE && w_full) begin
                r_ovf <= 1'b1;
            end
            if (READ && !r_valid) begin
                r_unf <= 1'b1;
            end
        end
    end

    assign FULL     = w_full;
    assign EMPTY    = !r_valid;
    assign DATA_OUT = r_dout;
    assign SIZE     = r_size;
    assign OVF      = r_ovf;
    assign UNF      = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_asym_width_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_asym_width_fifo
//  Brief    : Directed self-checking bench for asym_width_fifo (three configs).
//  Revision : 1.0
// ============================================================================
module tb_asym_width_fifo;

    logic clk;
    logic rst_n;

    // a: 8->32, DEPTH 64
    logic        a_flush, a_wr, a_rd, a_full, a_empty, a_ovf, a_unf;
    logic [7:0]  a_din;
    logic [31:0] a_dout;
    logic [6:0]  a_size;
    // b: 32->8, DEPTH 16
    logic        b_flush, b_wr, b_rd, b_full, b_empty, b_ovf, b_unf;
    logic [31:0] b_din;
    logic [7:0]  b_dout;
    logic [4:0]  b_size;
    // c: 8->32, DEPTH 16
    logic        c_flush, c_wr, c_rd, c_full, c_empty, c_ovf, c_unf;
    logic [7:0]  c_din;
    logic [31:0] c_dout;
    logic [4:0]  c_size;

    int n_total = 0;
    int n_bad   = 0;

    asym_width_fifo #(.WIDTH_IN(8), .WIDTH_OUT(32), .DEPTH(64)) u_a (
        .CLK(clk), .RST_N(rst_n), .FLUSH(a_flush), .WRITE(a_wr), .DATA_IN(a_din),
        .FULL(a_full), .READ(a_rd), .DATA_OUT(a_dout), .EMPTY(a_empty),
        .SIZE(a_size), .OVF(a_ovf), .UNF(a_unf));

    asym_width_fifo #(.WIDTH_IN(32), .WIDTH_OUT(8), .DEPTH(16)) u_b (
        .CLK(clk), .RST_N(rst_n), .FLUSH(b_flush), .WRITE(b_wr), .DATA_IN(b_din),
        .FULL(b_full), .READ(b_rd), .DATA_OUT(b_dout), .EMPTY(b_empty),
        .SIZE(b_size), .OVF(b_ovf), .UNF(b_unf));

    asym_width_fifo #(.WIDTH_IN(8), .WIDTH_OUT(32), .DEPTH(16)) u_c (
        .CLK(clk), .RST_N(rst_n), .FLUSH(c_flush), .WRITE(c_wr), .DATA_IN(c_din),
        .FULL(c_full), .READ(c_rd), .DATA_OUT(c_dout), .EMPTY(c_empty),
        .SIZE(c_size), .OVF(c_ovf), .UNF(c_unf));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rx;
        int tx;
        int max_size;
        logic [31:0] exp_w;

        rst_n = 1'b0;
        {a_flush, a_wr, a_rd, b_flush, b_wr, b_rd, c_flush, c_wr, c_rd} = '0;
        a_din = '0; b_din = '0; c_din = '0;
        #12;
        rst_n = 1'b1;
        tick();

        chk("rst_size", 64'(a_size), 64'd0);
        chk("rst_empty", 64'(a_empty), 64'd1);
        chk("rst_full", 64'(a_full), 64'd0);
        chk("rst_dout", 64'(a_dout), 64'd0);

        // Test 1: 8->32 packing
        a_wr = 1'b1;
        a_din = 8'h11; tick();
        chk("t1_size1", 64'(a_size), 64'd1);
        chk("t1_empty1", 64'(a_empty), 64'd1);
        a_din = 8'h22; tick();
        chk("t1_size2", 64'(a_size), 64'd2);
        a_din = 8'h33; tick();
        chk("t1_size3", 64'(a_size), 64'd3);
        chk("t1_empty3", 64'(a_empty), 64'd1);
        a_din = 8'h44; tick();
        a_wr = 1'b0;
        chk("t1_empty_at4", 64'(a_empty), 64'd1);
        tick();
        chk("t1_empty_after", 64'(a_empty), 64'd0);
        chk("t1_dout", 64'(a_dout), 64'h44332211);
        chk("t1_size4", 64'(a_size), 64'd4);
        a_rd = 1'b1; tick(); a_rd = 1'b0;
        chk("t1_pop_empty", 64'(a_empty), 64'd1);
        chk("t1_pop_size", 64'(a_size), 64'd0);

        // Test 2: 32->8 unpacking with READ held
        b_wr = 1'b1; b_din = 32'hA1B2C3D4; tick(); b_wr = 1'b0;
        tick();
        chk("t2_empty", 64'(b_empty), 64'd0);
        chk("t2_d0", 64'(b_dout), 64'hD4);
        b_rd = 1'b1; tick();
        chk("t2_d1", 64'(b_dout), 64'hC3);
        tick();
        chk("t2_d2", 64'(b_dout), 64'hB2);
        tick();
        chk("t2_d3", 64'(b_dout), 64'hA1);
        chk("t2_d3_valid", 64'(b_empty), 64'd0);
        tick(); b_rd = 1'b0;
        chk("t2_end_empty", 64'(b_empty), 64'd1);
        chk("t2_end_size", 64'(b_size), 64'd0);
        chk("t2_unf", 64'(b_unf), 64'd0);

        // Test 3: fill to FULL, overflow, drain
        c_wr = 1'b1;
        for (int i = 0; i < 16; i++) begin
            c_din = 8'(i);
            tick();
        end
        chk("t3_full", 64'(c_full), 64'd1);
        chk("t3_size", 64'(c_size), 64'd16);
        c_din = 8'hFF; tick(); c_wr = 1'b0;
        chk("t3_ovf", 64'(c_ovf), 64'd1);
        chk("t3_size_ovf", 64'(c_size), 64'd16);
        c_rd = 1'b1;
        for (int j = 0; j < 4; j++) begin
            exp_w = {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)};
            chk("t3_rd_valid", 64'(c_empty), 64'd0);
            chk("t3_rd_data", 64'(c_dout), 64'(exp_w));
            tick();
        end
        c_rd = 1'b0;
        chk("t3_drained", 64'(c_empty), 64'd1);
        chk("t3_drained_size", 64'(c_size), 64'd0);

        c_flush = 1'b1; tick(); c_flush = 1'b0;
        chk("t3_flush_ovf", 64'(c_ovf), 64'd0);

        // Test 4: continuous write and read through pointer wrap
        rx = 0; tx = 0; max_size = 0;
        for (int cyc = 0; cyc < 2000 && rx < 100; cyc++) begin
            c_wr  = (!c_full && tx < 400);
            c_din = 8'(tx);
            c_rd  = !c_empty;
            if (!c_empty) begin
                exp_w = {8'(4*rx+3), 8'(4*rx+2), 8'(4*rx+1), 8'(4*rx)};
                chk("t4_word", 64'(c_dout), 64'(exp_w));
                rx++;
            end
            if (c_wr) tx++;
            if (int'(c_size) > max_size) max_size = int'(c_size);
            tick();
        end
        c_wr = 1'b0; c_rd = 1'b0;
        chk("t4_count", 64'(rx), 64'd100);
        chk("t4_max_size_le16", 64'(max_size <= 16), 64'd1);
        chk("t4_ovf", 64'(c_ovf), 64'd0);
        chk("t4_unf", 64'(c_unf), 64'd0);

        // Test 5: FLUSH mid-packing, then async reset
        a_wr = 1'b1;
        a_din = 8'hA0; tick();
        a_din = 8'hA1; tick();
        a_din = 8'hA2; tick();
        a_din = 8'hA3; a_flush = 1'b1; tick(); a_flush = 1'b0;
        a_wr = 1'b0;
        chk("t5_flush_size", 64'(a_size), 64'd0);
        chk("t5_flush_empty", 64'(a_empty), 64'd1);
        tick();
        chk("t5_flush_stays_empty", 64'(a_empty), 64'd1);
        a_wr = 1'b1;
        a_din = 8'h55; tick();
        a_din = 8'h66; tick();
        a_din = 8'h77; tick();
        a_din = 8'h88; tick();
        a_wr = 1'b0; tick();
        chk("t5_fresh_word", 64'(a_dout), 64'h88776655);
        a_wr = 1'b1;
        a_din = 8'h99; tick();
        a_wr = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_size", 64'(a_size), 64'd0);
        chk("t5_rst_empty", 64'(a_empty), 64'd1);
        chk("t5_rst_dout", 64'(a_dout), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Test 6: READ while EMPTY, then FLUSH
        b_rd = 1'b1; tick(); b_rd = 1'b0;
        chk("t6_unf", 64'(b_unf), 64'd1);
        chk("t6_size", 64'(b_size), 64'd0);
        b_flush = 1'b1; tick(); b_flush = 1'b0;
        chk("t6_unf_clr", 64'(b_unf), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
